mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Owns the single memory port and the 8-bit memory address register.
- Arbitrates between two requesters:
  - instruction fetch (address from PC);
  - operand access (address from MBR), read or write.
- Sequences each access through address-load, wait and complete phases, then returns the read data with a one-cycle done pulse.
- Sits between the control unit and memory, replacing the ad-hoc MAR load strobes with a request/done handshake.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 16, memory data width.
- MEM_LAT, 1, cycles from address stable to read data valid or write committed; legal range 1..7.
- STARVE_MAX, 3, consecutive operand grants allowed while a fetch is pending before fetch is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch address (PC); sampled at grant.
- op_req  in  1  operand request; held high until op_done.
- op_we  in  1  1 = write, 0 = read; sampled at grant.
- op_addr  in  ADDR_W  operand address (MBR); sampled at grant.
- op_wdata  in  DATA_W  write data; sampled at grant.
- if_done  out  1  one-cycle pulse; rdata valid for the fetch.
- op_done  out  1  one-cycle pulse; operand access complete, rdata valid if read.
- rdata  out  DATA_W  registered read data; holds until the next read completes.
- mem_addr  out  ADDR_W  address-register contents to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_re is first asserted.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE;
  - mem_addr = 0, mem_wdata = 0, rdata = 0;
  - mem_we = mem_re = 0, if_done = op_done = 0, busy = 0;
  - starve counter = 0.
  - Reset asserted mid-access aborts the access: no done pulse, mem_we deasserts on the next edge.
- States: IDLE -> LOAD -> WAIT -> DONE -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: grant per arbitration, go to LOAD.
- Arbitration (evaluated in IDLE only):
  - op_req wins over if_req, except when starve counter == STARVE_MAX and if_req = 1; fetch then wins.
  - Starve counter increments on each operand grant made while if_req = 1.
  - Starve counter clears on every fetch grant, and when if_req = 0 at arbitration.
  - Counter saturates at STARVE_MAX.
- LOAD (1 cycle):
  - Register the granted address into mem_addr; for writes, also register op_wdata into mem_wdata.
  - Latch the grant owner and the write flag.
  - Go to WAIT.
- WAIT (MEM_LAT cycles):
  - Read: mem_re = 1 throughout WAIT.
  - Write: mem_we = 1 throughout WAIT.
  - mem_addr and mem_wdata held stable.
  - Internal countdown loads MEM_LAT-1 on entry; leave when it reaches 0.
  - On the last WAIT cycle of a read, capture mem_rdata into rdata.
- DONE (1 cycle):
  - Strobes low; pulse if_done or op_done for the owner.
  - Go to IDLE.
  - The requester drops its req in the cycle after done; a req still high one cycle after done is a new request.
- Latency, request seen in IDLE -> done pulse: 2 + MEM_LAT cycles (3 at default).
  - Back-to-back throughput: one access per 3 + MEM_LAT cycles (IDLE cycle included).
- Boundary and simultaneous conditions:
  - Request inputs are ignored outside IDLE; address and data changes after grant have no effect.
  - Both requests in the same cycle: operand granted; fetch stays pending.
  - Address 0xFF is a normal address, no wrap special-casing.
  - A write never modifies rdata.
  - mem_we and mem_re are never high together.
  - At most one of if_done and op_done is high in any cycle.

Test Plan:
- Reset, then idle: rst = 1 for 2 cycles, no requests -> all outputs 0, busy = 0, mem_addr = 0x00.
- Single fetch: if_req = 1, if_addr = 0x3C, memory returns 0xA55A.
  - mem_addr = 0x3C from the cycle after grant.
  - mem_re high 1 cycle.
  - if_done pulses 3 cycles after the request; rdata = 0xA55A.
- Operand write: op_req = 1, op_we = 1, op_addr = 0xFF, op_wdata = 0x1234.
  - mem_we high 1 cycle with mem_addr = 0xFF, mem_wdata = 0x1234.
  - op_done pulses; rdata unchanged.
- Simultaneous requests: if_req = op_req = 1 at the same edge.
  - Operand served first (op_done), then fetch (if_done), 4 cycles apart.
- Starvation guard: if_req held high, op_req re-asserted back-to-back.
  - Exactly 3 operand grants, then a fetch grant, then the operand resumes.
- Reset mid-access with MEM_LAT = 3, write in progress: assert rst in the 2nd WAIT cycle.
  - Next edge: mem_we = 0, state IDLE, no op_done pulse.
  - After release, a new read to 0x10 completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: arbitrates fetch and operand requests onto one memory
// port, sequencing each access through LOAD, WAIT and DONE phases.
module mem_access_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              op_req,
  input  logic              op_we,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              if_done,
  output logic              op_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = 3;
  localparam int SW    = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_own_op;
  logic              r_we;
  logic [ADDR_W-1:0] r_gnt_addr;
  logic [DATA_W-1:0] r_gnt_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [SW-1:0]     r_starve;

  logic w_any;
  logic w_force_if;
  logic w_gnt_op;
  logic w_gnt_if;

  // Fetch is forced once the operand side has won STARVE_MAX times in a row.
  assign w_any      = if_req | op_req;
  assign w_force_if = if_req && (r_starve == SW'(STARVE_MAX));
  assign w_gnt_op   = op_req && !w_force_if;
  assign w_gnt_if   = if_req && !w_gnt_op;

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;

  always_comb begin
    w_state_nxt = r_state;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    if_done     = 1'b0;
    op_done     = 1'b0;
    busy        = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mem_re = !r_we;
        mem_we = r_we;
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if_done     = !r_own_op;
        op_done     = r_own_op;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_own_op    <= 1'b0;
      r_we        <= 1'b0;
      r_gnt_addr  <= '0;
      r_gnt_wdata <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_starve    <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_own_op    <= w_gnt_op;
            r_we        <= w_gnt_op & op_we;
            r_gnt_addr  <= w_gnt_op ? op_addr : if_addr;
            r_gnt_wdata <= op_wdata;
          end
          if (!if_req || w_gnt_if) begin
            r_starve <= '0;
          end else if (w_gnt_op && r_starve != SW'(STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        S_LOAD: begin
          r_mem_addr <= r_gnt_addr;
          if (r_we) r_mem_wdata <= r_gnt_wdata;
          r_cnt <= CNT_W'(MEM_LAT - 1);
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_we) begin
            r_rdata <= mem_rdata;
          end
        end
        S_DONE: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: cycle-timeline reference model under random
// traffic, plus literal cases for latency, arbitration, starvation, reset abort.
`timescale 1ns/1ps
module tb_mem_access_sequencer;

  localparam int L    = 1;
  localparam int L3   = 3;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst, if_req, op_req, op_we;
  logic [7:0]  if_addr, op_addr, mem_addr;
  logic [15:0] op_wdata, mem_rdata, rdata, mem_wdata;
  logic        if_done, op_done, mem_we, mem_re, busy;

  logic        rst_3, if_req_3, op_req_3, op_we_3;
  logic [7:0]  if_addr_3, op_addr_3, mem_addr_3;
  logic [15:0] op_wdata_3, mem_rdata_3, rdata_3, mem_wdata_3;
  logic        if_done_3, op_done_3, mem_we_3, mem_re_3, busy_3;

  mem_access_sequencer #(.MEM_LAT(L)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .op_req(op_req), .op_we(op_we), .op_addr(op_addr), .op_wdata(op_wdata),
    .if_done(if_done), .op_done(op_done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_access_sequencer #(.MEM_LAT(L3)) u_dut3 (
    .clk(clk), .rst(rst_3),
    .if_req(if_req_3), .if_addr(if_addr_3),
    .op_req(op_req_3), .op_we(op_we_3), .op_addr(op_addr_3), .op_wdata(op_wdata_3),
    .if_done(if_done_3), .op_done(op_done_3), .rdata(rdata_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_we(mem_we_3), .mem_re(mem_re_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a ^ 8'h99, a ^ 8'h66};
  endfunction

  // Memory: data valid only on the MEM_LAT-th read cycle, write commits on the last one.
  logic [15:0] mem [256];
  logic        wr_v [256] = '{default: 1'b0};
  int re_cnt = 0, we_cnt = 0, re_cnt3 = 0;

  always @(posedge clk) begin
    re_cnt  <= mem_re ? re_cnt + 1 : 0;
    we_cnt  <= mem_we ? we_cnt + 1 : 0;
    re_cnt3 <= mem_re_3 ? re_cnt3 + 1 : 0;
    if (mem_we && we_cnt == L - 1) begin
      mem[mem_addr]  <= mem_wdata;
      wr_v[mem_addr] <= 1'b1;
    end
  end

  assign mem_rdata = (mem_re && re_cnt == L - 1) ?
    (wr_v[mem_addr] ? mem[mem_addr] : init_val(mem_addr)) : 16'hDEAD;
  assign mem_rdata_3 = (mem_re_3 && re_cnt3 == L3 - 1) ?
    init_val(mem_addr_3) : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each grant at cycle g implies LOAD at g+1,
  // WAIT at g+2..g+1+L, DONE at g+2+L.
  logic [15:0] shadow [256];
  initial begin : model
    int cyc, tg, off, starve;
    bit armed, act, t_op, t_we;
    bit e_busy, e_re, e_we, e_ifd, e_opd;
    logic [7:0]  t_addr, e_addr;
    logic [15:0] t_wd, e_wd, e_rd;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
    cyc = 0; tg = 0; starve = 0; armed = 0; act = 0; t_op = 0; t_we = 0;
    t_addr = '0; t_wd = '0; e_addr = '0; e_wd = '0; e_rd = '0;
    forever begin
      @(negedge clk);
      if (armed && !rst && !act) begin
        if (op_req && !(if_req && starve == SMAX)) begin
          act = 1; tg = cyc; t_op = 1; t_we = op_we;
          t_addr = op_addr; t_wd = op_wdata;
          starve = if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        end else if (if_req) begin
          act = 1; tg = cyc; t_op = 0; t_we = 0;
          t_addr = if_addr; starve = 0;
        end else begin
          starve = 0;
        end
      end
      off    = act ? cyc - tg : 0;
      e_busy = act && off >= 1;
      e_re   = act && !t_we && off >= 2 && off <= 1 + L;
      e_we   = act && t_we && off >= 2 && off <= 1 + L;
      e_ifd  = act && !t_op && off == 2 + L;
      e_opd  = act && t_op && off == 2 + L;
      if (act && off == 2) begin
        e_addr = t_addr;
        if (t_we) e_wd = t_wd;
      end
      if (act && !t_we && off == 2 + L) e_rd = shadow[t_addr];
      if (armed) begin
        check("busy", busy, e_busy);
        check("mem_re", mem_re, e_re);
        check("mem_we", mem_we, e_we);
        check("if_done", if_done, e_ifd);
        check("op_done", op_done, e_opd);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wd);
        check("rdata", rdata, e_rd);
        check("strobe_excl", mem_we & mem_re, 0);
        check("done_excl", if_done & op_done, 0);
      end
      if (act && t_we && off == 1 + L) shadow[t_addr] = t_wd;
      if (act && off == 2 + L) act = 0;
      if (rst) begin
        act = 0; starve = 0; e_addr = '0; e_wd = '0; e_rd = '0; armed = 1;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic await_done(input bit want_op, output int lat,
                            output int re_n, output int we_n,
                            output logic [7:0] sa, output logic [15:0] swd);
    lat = 0; re_n = 0; we_n = 0; sa = '0; swd = '0;
    @(negedge clk);
    while (!(want_op ? op_done : if_done) && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_re) begin re_n++; sa = mem_addr; end
      if (mem_we) begin we_n++; sa = mem_addr; swd = mem_wdata; end
    end
  endtask

  initial begin : driver
    int lat, lat2, re_n, we_n, k, n, od;
    logic [7:0]  sa;
    logic [15:0] swd;
    logic [4:0]  seq;
    bit d_if, d_op, drop;

    rst = 1; if_req = 0; op_req = 0; op_we = 0;
    if_addr = '0; op_addr = '0; op_wdata = '0;
    rst_3 = 1; if_req_3 = 0; op_req_3 = 0; op_we_3 = 0;
    if_addr_3 = '0; op_addr_3 = '0; op_wdata_3 = '0;

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_rdata", rdata, 0);
    check("rst_strobes", {mem_we, mem_re, if_done, op_done}, 0);

    tick(); if_req = 1; if_addr = 8'h3C;
    await_done(0, lat, re_n, we_n, sa, swd);
    check("fetch_lat", lat, 3);
    check("fetch_re_cycles", re_n, 1);
    check("fetch_addr", sa, 8'h3C);
    check("fetch_rdata", rdata, 16'hA55A);
    tick(); if_req = 0;

    tick(); op_req = 1; op_we = 1; op_addr = 8'hFF; op_wdata = 16'h1234;
    await_done(1, lat, re_n, we_n, sa, swd);
    check("wr_lat", lat, 3);
    check("wr_we_cycles", we_n, 1);
    check("wr_re_cycles", re_n, 0);
    check("wr_addr", sa, 8'hFF);
    check("wr_wdata", swd, 16'h1234);
    check("wr_rdata_kept", rdata, 16'hA55A);
    tick(); op_req = 0;

    tick(); if_req = 1; op_req = 1; op_we = 0; if_addr = 8'h41; op_addr = 8'hFF;
    await_done(1, lat, re_n, we_n, sa, swd);
    check("sim_op_lat", lat, 3);
    check("sim_op_rdata", rdata, 16'h1234);
    tick(); op_req = 0;
    await_done(0, lat2, re_n, we_n, sa, swd);
    check("sim_gap", lat2 + 1, 4);
    check("sim_if_rdata", rdata, 16'hD827);
    tick(); if_req = 0;

    tick(); if_req = 1; if_addr = 8'h22; op_req = 1; op_we = 0; op_addr = 8'h33;
    k = 0; n = 0; seq = '0;
    while (k < 5 && n < 60) begin
      @(negedge clk);
      n++;
      drop = 0;
      if (op_done && k < 5) begin seq[k] = 1'b1; k++; end
      if (if_done && k < 5) begin seq[k] = 1'b0; k++; drop = 1; end
      tick();
      if (drop) if_req = 0;
    end
    op_req = 0;
    check("starve_count", k, 5);
    check("starve_order", seq, 5'b10111);

    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      d_if = if_done; d_op = op_done;
      tick();
      if (d_if) if_req = ($urandom_range(0, 3) == 0);
      else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      if (d_op) op_req = ($urandom_range(0, 2) == 0);
      else if (!op_req) op_req = ($urandom_range(0, 1) == 0);
      if_addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      op_addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      op_we    = 1'($urandom);
      op_wdata = 16'($urandom);
      rst      = ($urandom_range(0, 149) == 0);
    end
    rst = 0; if_req = 0; op_req = 0;
    repeat (6) tick();

    rst_3 = 0;
    tick(); op_req_3 = 1; op_we_3 = 1; op_addr_3 = 8'h20; op_wdata_3 = 16'hBEEF;
    tick();
    tick();
    @(negedge clk);
    check("l3_we_wait1", mem_we_3, 1);
    tick(); rst_3 = 1; op_req_3 = 0;
    @(negedge clk);
    check("l3_we_wait2", mem_we_3, 1);
    tick(); rst_3 = 0;
    @(negedge clk);
    check("l3_abort_we", mem_we_3, 0);
    check("l3_abort_busy", busy_3, 0);
    od = 0;
    repeat (6) begin
      @(negedge clk);
      if (op_done_3) od++;
      tick();
    end
    check("l3_abort_no_done", od, 0);

    op_req_3 = 1; op_we_3 = 0; op_addr_3 = 8'h10;
    lat = 0; re_n = 0; sa = '0;
    @(negedge clk);
    while (!op_done_3 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_re_3) begin re_n++; sa = mem_addr_3; end
    end
    check("l3_rd_lat", lat, 5);
    check("l3_rd_re_cycles", re_n, 3);
    check("l3_rd_addr", sa, 8'h10);
    check("l3_rd_rdata", rdata_3, 16'h8976);
    tick(); op_req_3 = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
